// File: rtl/tpu_c_drain_if.sv
// Result stream from the C-drain block to its sink: one array row per beat.
interface tpu_c_drain_if #(
    parameter int BITS_C = 16,
    parameter int ROWS   = 8,
    parameter int COLS   = 8
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int DATA_W = COLS * BITS_C;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/tpu_c_drain.sv
// Unloads the accumulated C values of a systolic MAC array. Each wr_en pulse
// shifts every column chain down one row; the bottom row is captured on that
// same edge and streamed out as one beat, bottom row (ROWS-1) first.
module tpu_c_drain #(
    parameter int BITS_C = 16,
    parameter int ROWS   = 8,
    parameter int COLS   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_en,
    output logic [COLS*BITS_C-1:0]   c_fill,
    input  logic [COLS*BITS_C-1:0]   c_tail,
    tpu_c_drain_if.master            out_if
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = $clog2(ROWS + 1);
    localparam int DATA_W = COLS * BITS_C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic               valid_r;
    logic               valid_s;
    logic               done_r;
    logic               done_s;
    logic               cap_s;
    logic               slot_free_s;
    logic [DATA_W-1:0]  data_r;
    logic [ROW_W-1:0]   row_r;
    logic               last_r;

    // Zeros enter at the top so the array is clear once the drain completes.
    assign c_fill = '0;

    // The output slot can take a new row when empty or being emptied this cycle.
    assign slot_free_s = !valid_r || out_if.out_ready;

    // Next-state, shift strobe and capture decisions.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        valid_s = valid_r;
        done_s  = 1'b0;
        cap_s   = 1'b0;
        wr_en   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_DRAIN;
                    count_s = CNT_W'(ROWS);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (slot_free_s) begin
                    // Shift and capture on the same edge: next cycle sees the next row.
                    wr_en   = 1'b1;
                    cap_s   = 1'b1;
                    valid_s = 1'b1;
                    count_s = count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_s = S_FLUSH;
                    end else begin
                        state_s = S_DRAIN;
                    end
                end else begin
                    // Sink is stalling: hold the chain and the pending beat.
                    state_s = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (valid_r && out_if.out_ready) begin
                    valid_s = 1'b0;
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            default: begin
                state_s = S_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            count_r <= CNT_W'(ROWS);
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    // Beat payload: captured bit-exact from the bottom row on each shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            row_r  <= '0;
            last_r <= 1'b0;
        end else if (cap_s) begin
            data_r <= c_tail;
            row_r  <= ROW_W'(count_r - CNT_W'(1));
            last_r <= (count_r == CNT_W'(1));
        end
    end

    assign busy             = (state_r != S_IDLE);
    assign done             = done_r;
    assign out_if.out_valid = valid_r;
    assign out_if.out_data  = data_r;
    assign out_if.out_row   = row_r;
    assign out_if.out_last  = last_r;
endmodule
